tetris_phase_sequencer: RTL and testbench
=========================================

TETRIS_PHASE_SEQUENCER -- requirements
Module: tetris_phase_sequencer

Interface
REQ-001 Parameters (name, default, meaning):
- DROP_BASE, 1000: gravity period at level 0, in tick strobes.
- DROP_STEP, 60: period reduction per level.
- DROP_MIN, 100: period floor.
- LINES_PER_LEVEL, 10: cleared lines per level increment.
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  single clock.
- reset  in  1  synchronous, active-low.
- start  in  1  one-cycle new-game pulse.
- tick  in  1  one-cycle timebase strobe.
- move_valid  in  1  move request valid.
- move  in  tetris_pkg::command_t  requested move.
- move_ready  out  1  move request accepted this cycle.
- left_blocked  in  1  collision flag.
- right_blocked  in  1  collision flag.
- rot_blocked  in  1  collision flag.
- down_blocked  in  1  collision flag.
- spawn_blocked  in  1  freshly spawned piece overlaps the fixed board.
- any_full_row  in  1  fixed board holds at least one full row.
- board_clear  out  1  pulse: blank the fixed board.
- spawn_en  out  1  pulse: load the new piece.
- move_en  out  1  pulse: apply move_cmd.
- move_cmd  out  tetris_pkg::command_t  registered accepted command.
- drop_en  out  1  pulse: y+1.
- lock_en  out  1  pulse: merge the piece into the fixed board.
- clear_en  out  1  pulse: remove the bottom-most full row.
- game_over  out  1  level signal.
- phase  out  phase_t  current state.
- lines_cleared  out  16  total lines cleared.
- level  out  4  current level.

Function
REQ-003 States are IDLE, SPAWN, SETTLE, FALL, LOCK, CLEAR, CLEAR_WAIT and OVER.
REQ-004 In IDLE, start causes board_clear for one cycle, zeroes the counters, and moves the FSM to SPAWN.
REQ-005 SPAWN asserts spawn_en for exactly one cycle and then moves to SETTLE.
REQ-006 SETTLE samples spawn_blocked, moving to OVER if it is 1 and to FALL otherwise, with the gravity counter zeroed.
REQ-007 In FALL, the gravity counter increments on each tick; the gravity event (grav_due) occurs when tick=1 and count = period-1.
REQ-008 On grav_due, the counter resets to 0; with down_blocked=0 the block asserts drop_en for one cycle and stays in FALL; with down_blocked=1 it goes to LOCK with no drop_en.
REQ-009 move_ready = (phase==FALL) & ~grav_due, so gravity wins over a simultaneous move and the move is held by the requester.
REQ-010 On move_valid & move_ready, the command is consumed.
- CMD_LEFT with left_blocked=0, CMD_RIGHT with right_blocked=0, or CMD_ROTATE with rot_blocked=0: move_en=1 and move_cmd=move on the next cycle.
- Blocked or other commands: consumed silently with no move_en.
REQ-011 move_en and drop_en are never asserted in the same cycle.
REQ-012 LOCK asserts lock_en for one cycle and then moves to CLEAR.
REQ-013 CLEAR samples any_full_row.
- If 1: asserts clear_en for one cycle, increments lines_cleared (saturating at 16'hFFFF) and moves to CLEAR_WAIT.
- If 0: moves to SPAWN.
REQ-014 CLEAR_WAIT lasts one cycle for the board update and then returns to CLEAR, so multiple full rows are cleared one per two cycles.
REQ-015 level = min(15, lines_cleared / LINES_PER_LEVEL) and is registered.
REQ-016 period = max(DROP_MIN, DROP_BASE - level*DROP_STEP), computed without underflow and sized for DROP_BASE.
REQ-017 OVER holds game_over=1 and ignores moves and ticks; start then behaves as in IDLE.
REQ-018 start outside IDLE/OVER aborts the game: board_clear, counters zeroed, next state SPAWN.
REQ-019 All pulse outputs are registered and are mutually exclusive, except board_clear, which may coincide only with the transition into SPAWN.

Reset
REQ-020 When reset=0 at a clk edge, the block enters IDLE with all pulses 0, game_over=0, lines_cleared=0, level=0, gravity counter=0, move_cmd=CMD_NONE, and move_ready=0.
REQ-021 A reset during any state, including CLEAR_WAIT and mid-move, takes effect in one cycle with no residual pulse.

Structure
REQ-022 phase_t and the parameter defaults belong in tetris_pkg; command_t is reused from it.
REQ-023 One sub-module, gravity_timer (tick counter, period computation, grav_due), is instantiated; the FSM stays in this module.

Verification
REQ-024 Reset, then start: board_clear, then spawn_en, then phase=FALL; with no spawn_blocked, game_over stays 0.
REQ-025 DROP_BASE=4, tick every cycle, down_blocked=0: drop_en every 4th tick; after down_blocked=1 the next grav_due gives lock_en and no drop_en.
REQ-026 move_valid held with CMD_LEFT arriving on the same cycle as grav_due: move_ready=0, drop_en=1; the move is accepted next cycle and move_en follows one cycle later.
REQ-027 any_full_row held 1 for 3 CLEAR samples: exactly 3 clear_en pulses two cycles apart, lines_cleared +3, then spawn_en.
REQ-028 lines_cleared reaching 10: level=1 and period=940; from level 15, period=100 (floor).
REQ-029 spawn_blocked=1 in SETTLE: game_over=1 and moves/ticks are ignored; then reset=0 for one cycle returns the block to IDLE with game_over=0.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared types and parameter defaults for the falling-block game sequencer.
package tetris_pkg;

  localparam int unsigned DROP_BASE_DEF       = 1000;
  localparam int unsigned DROP_STEP_DEF       = 60;
  localparam int unsigned DROP_MIN_DEF        = 100;
  localparam int unsigned LINES_PER_LEVEL_DEF = 10;
  localparam int unsigned LEVEL_MAX           = 15;

  typedef enum logic [2:0] {
    CMD_NONE   = 3'd0,
    CMD_LEFT   = 3'd1,
    CMD_RIGHT  = 3'd2,
    CMD_ROTATE = 3'd3,
    CMD_DOWN   = 3'd4,
    CMD_DROP   = 3'd5
  } command_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SPAWN      = 3'd1,
    SETTLE     = 3'd2,
    FALL       = 3'd3,
    LOCK       = 3'd4,
    CLEAR      = 3'd5,
    CLEAR_WAIT = 3'd6,
    OVER       = 3'd7
  } phase_t;

endpackage

// File: rtl/tetris_phase_sequencer_gravity_timer.sv
// Gravity timer: counts tick strobes while the piece is falling and flags the
// gravity event once the level-dependent period has elapsed.
module gravity_timer
  import tetris_pkg::*;
#(
  parameter int unsigned DROP_BASE = DROP_BASE_DEF,
  parameter int unsigned DROP_STEP = DROP_STEP_DEF,
  parameter int unsigned DROP_MIN  = DROP_MIN_DEF,
  parameter int unsigned PW        = $clog2(DROP_BASE + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          run_i,
  input  logic          tick_i,
  input  logic [3:0]    level_i,
  output logic          grav_due_o,
  output logic [PW-1:0] period_o
);

  logic [PW-1:0] cnt_q, cnt_d;
  logic [31:0]   reduction;
  logic [31:0]   period_full;

  // Period shrinks with level; the subtraction is guarded so it never wraps.
  always_comb begin
    reduction   = 32'(level_i) * DROP_STEP;
    period_full = DROP_MIN;
    if ((reduction < DROP_BASE) && ((DROP_BASE - reduction) > DROP_MIN)) begin
      period_full = DROP_BASE - reduction;
    end
    period_o = PW'(period_full);
  end

  // Gravity event and next count.
  always_comb begin
    grav_due_o = run_i & tick_i & (cnt_q == (period_o - PW'(1)));
    cnt_d      = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i && tick_i) begin
      cnt_d = grav_due_o ? '0 : cnt_q + PW'(1);
    end
  end

  // Tick counter register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tetris_phase_sequencer.sv
// Game phase sequencer: spawn, fall under gravity, accept moves, lock the
// piece, clear full rows one at a time, and detect game over.
module tetris_phase_sequencer
  import tetris_pkg::*;
#(
  parameter int unsigned DROP_BASE       = DROP_BASE_DEF,
  parameter int unsigned DROP_STEP       = DROP_STEP_DEF,
  parameter int unsigned DROP_MIN        = DROP_MIN_DEF,
  parameter int unsigned LINES_PER_LEVEL = LINES_PER_LEVEL_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        tick,
  input  logic        move_valid,
  input  command_t    move,
  output logic        move_ready,
  input  logic        left_blocked,
  input  logic        right_blocked,
  input  logic        rot_blocked,
  input  logic        down_blocked,
  input  logic        spawn_blocked,
  input  logic        any_full_row,
  output logic        board_clear,
  output logic        spawn_en,
  output logic        move_en,
  output command_t    move_cmd,
  output logic        drop_en,
  output logic        lock_en,
  output logic        clear_en,
  output logic        game_over,
  output phase_t      phase,
  output logic [15:0] lines_cleared,
  output logic [3:0]  level
);

  localparam int unsigned PW = $clog2(DROP_BASE + 1);

  phase_t      state_q, state_d;
  command_t    cmd_q, cmd_d;
  logic        board_clear_q, board_clear_d;
  logic        spawn_en_q, spawn_en_d;
  logic        move_en_q, move_en_d;
  logic        drop_en_q, drop_en_d;
  logic        lock_en_q, lock_en_d;
  logic        clear_en_q, clear_en_d;
  logic        over_q, over_d;
  logic [15:0] lines_q, lines_d;
  logic [3:0]  level_q, level_d;
  logic [31:0] level_full;
  logic        grav_due;
  logic        move_ok;
  logic        timer_clear;
  logic [PW-1:0] period;

  assign timer_clear = start | (state_q == SETTLE);

  gravity_timer #(
    .DROP_BASE (DROP_BASE),
    .DROP_STEP (DROP_STEP),
    .DROP_MIN  (DROP_MIN),
    .PW        (PW)
  ) u_gravity (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (timer_clear),
    .run_i      (state_q == FALL),
    .tick_i     (tick),
    .level_i    (level_q),
    .grav_due_o (grav_due),
    .period_o   (period)
  );

  // Only lateral moves and rotation are actionable, and only when unobstructed.
  always_comb begin
    case (move)
      CMD_LEFT:   move_ok = ~left_blocked;
      CMD_RIGHT:  move_ok = ~right_blocked;
      CMD_ROTATE: move_ok = ~rot_blocked;
      default:    move_ok = 1'b0;
    endcase
  end

  // Next phase, registered pulses and line counter.
  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    lines_d       = lines_q;
    over_d        = over_q;
    board_clear_d = 1'b0;
    spawn_en_d    = 1'b0;
    move_en_d     = 1'b0;
    drop_en_d     = 1'b0;
    lock_en_d     = 1'b0;
    clear_en_d    = 1'b0;
    move_ready    = (state_q == FALL) & ~grav_due;
    if (start) begin
      board_clear_d = 1'b1;
      lines_d       = '0;
      over_d        = 1'b0;
      state_d       = SPAWN;
    end else begin
      case (state_q)
        IDLE: ;
        SPAWN: begin
          spawn_en_d = 1'b1;
          state_d    = SETTLE;
        end
        SETTLE: begin
          if (spawn_blocked) begin
            over_d  = 1'b1;
            state_d = OVER;
          end else begin
            state_d = FALL;
          end
        end
        FALL: begin
          if (grav_due) begin
            if (down_blocked) state_d = LOCK;
            else              drop_en_d = 1'b1;
          end else if (move_valid && move_ready && move_ok) begin
            move_en_d = 1'b1;
            cmd_d     = move;
          end
        end
        LOCK: begin
          lock_en_d = 1'b1;
          state_d   = CLEAR;
        end
        CLEAR: begin
          if (any_full_row) begin
            clear_en_d = 1'b1;
            if (lines_q != '1) lines_d = lines_q + 16'd1;
            state_d = CLEAR_WAIT;
          end else begin
            state_d = SPAWN;
          end
        end
        CLEAR_WAIT: state_d = CLEAR;
        OVER: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // Level follows the next line count so both registers update together.
  always_comb begin
    level_full = 32'(lines_d) / LINES_PER_LEVEL;
    level_d    = (level_full > LEVEL_MAX) ? 4'(LEVEL_MAX) : level_full[3:0];
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      cmd_q         <= CMD_NONE;
      lines_q       <= '0;
      level_q       <= '0;
      over_q        <= 1'b0;
      board_clear_q <= 1'b0;
      spawn_en_q    <= 1'b0;
      move_en_q     <= 1'b0;
      drop_en_q     <= 1'b0;
      lock_en_q     <= 1'b0;
      clear_en_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      lines_q       <= lines_d;
      level_q       <= level_d;
      over_q        <= over_d;
      board_clear_q <= board_clear_d;
      spawn_en_q    <= spawn_en_d;
      move_en_q     <= move_en_d;
      drop_en_q     <= drop_en_d;
      lock_en_q     <= lock_en_d;
      clear_en_q    <= clear_en_d;
    end
  end

  assign phase         = state_q;
  assign move_cmd      = cmd_q;
  assign board_clear   = board_clear_q;
  assign spawn_en      = spawn_en_q;
  assign move_en       = move_en_q;
  assign drop_en       = drop_en_q;
  assign lock_en       = lock_en_q;
  assign clear_en      = clear_en_q;
  assign game_over     = over_q;
  assign lines_cleared = lines_q;
  assign level         = level_q;

endmodule

// File: tb/tb_tetris_phase_sequencer.sv
// Bench for the phase sequencer: directed scenarios followed by random play,
// every cycle compared against a behavioural game model.
module tb_tetris_phase_sequencer;
  import tetris_pkg::*;

  localparam int TB_BASE = 4;
  localparam int TB_STEP = 1;
  localparam int TB_MIN  = 2;
  localparam int TB_LPL  = 2;

  logic clk = 1'b0;
  logic reset = 1'b0, start = 1'b0, tick = 1'b0, move_valid = 1'b0;
  command_t move = CMD_NONE;
  logic left_blocked = 1'b0, right_blocked = 1'b0, rot_blocked = 1'b0;
  logic down_blocked = 1'b0, spawn_blocked = 1'b0, any_full_row = 1'b0;
  logic move_ready, board_clear, spawn_en, move_en, drop_en, lock_en, clear_en, game_over;
  command_t move_cmd;
  phase_t phase;
  logic [15:0] lines_cleared;
  logic [3:0] level;

  tetris_phase_sequencer #(
    .DROP_BASE       (TB_BASE),
    .DROP_STEP       (TB_STEP),
    .DROP_MIN        (TB_MIN),
    .LINES_PER_LEVEL (TB_LPL)
  ) dut (
    .clk (clk), .reset (reset), .start (start), .tick (tick),
    .move_valid (move_valid), .move (move), .move_ready (move_ready),
    .left_blocked (left_blocked), .right_blocked (right_blocked),
    .rot_blocked (rot_blocked), .down_blocked (down_blocked),
    .spawn_blocked (spawn_blocked), .any_full_row (any_full_row),
    .board_clear (board_clear), .spawn_en (spawn_en), .move_en (move_en),
    .move_cmd (move_cmd), .drop_en (drop_en), .lock_en (lock_en),
    .clear_en (clear_en), .game_over (game_over), .phase (phase),
    .lines_cleared (lines_cleared), .level (level)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural game model
  phase_t   m_phase = IDLE;
  int       m_cnt = 0;
  int       m_lines = 0;
  command_t e_cmd = CMD_NONE;
  bit e_bclr, e_spawn, e_move, e_drop, e_lock, e_clear;
  bit warm = 0;

  function automatic int m_level(input int lines);
    int l = lines / TB_LPL;
    return (l > 15) ? 15 : l;
  endfunction

  function automatic int m_period(input int lvl);
    int p = TB_BASE - lvl * TB_STEP;
    return (p < TB_MIN) ? TB_MIN : p;
  endfunction

  function automatic bit m_due();
    return (m_phase == FALL) && tick && (m_cnt == m_period(m_level(m_lines)) - 1);
  endfunction

  task automatic model_step();
    bit legal;
    {e_bclr, e_spawn, e_move, e_drop, e_lock, e_clear} = '0;
    if (!reset) begin
      m_phase = IDLE; m_cnt = 0; m_lines = 0; e_cmd = CMD_NONE;
    end else if (start) begin
      e_bclr = 1; m_lines = 0; m_cnt = 0; m_phase = SPAWN;
    end else begin
      case (m_phase)
        SPAWN:  begin e_spawn = 1; m_phase = SETTLE; end
        SETTLE: begin m_cnt = 0; m_phase = spawn_blocked ? OVER : FALL; end
        FALL: begin
          if (m_due()) begin
            m_cnt = 0;
            if (down_blocked) m_phase = LOCK; else e_drop = 1;
          end else begin
            if (tick) m_cnt++;
            legal = (move == CMD_LEFT && !left_blocked) || (move == CMD_RIGHT && !right_blocked)
                 || (move == CMD_ROTATE && !rot_blocked);
            if (move_valid && legal) begin e_move = 1; e_cmd = move; end
          end
        end
        LOCK:  begin e_lock = 1; m_phase = CLEAR; end
        CLEAR: begin
          if (any_full_row) begin
            e_clear = 1;
            if (m_lines < 65535) m_lines++;
            m_phase = CLEAR_WAIT;
          end else m_phase = SPAWN;
        end
        CLEAR_WAIT: m_phase = CLEAR;
        default: ;
      endcase
    end
  endtask

  task automatic check_outputs();
    chk("board_clear", board_clear, e_bclr);
    chk("spawn_en", spawn_en, e_spawn);
    chk("move_en", move_en, e_move);
    chk("move_cmd", move_cmd, e_cmd);
    chk("drop_en", drop_en, e_drop);
    chk("lock_en", lock_en, e_lock);
    chk("clear_en", clear_en, e_clear);
    chk("game_over", game_over, m_phase == OVER);
    chk("phase", phase, m_phase);
    chk("lines_cleared", lines_cleared, m_lines);
    chk("level", level, m_level(m_lines));
    chk("period", dut.u_gravity.period_o, m_period(m_level(m_lines)));
    chk("pulse_excl", ($countones({spawn_en, move_en, drop_en, lock_en, clear_en}) <= 1), 1);
  endtask

  // Inputs are already driven (at negedge); check, clock, model, check.
  task automatic cycle();
    #1;
    if (warm) chk("move_ready", move_ready, m_due() ? 1'b0 : (m_phase == FALL));
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
    warm = 1;
    @(negedge clk);
  endtask

  task automatic run_until(input phase_t ph, input int limit, input string tag);
    int n = 0;
    while (m_phase != ph && n < limit) begin cycle(); n++; end
    chk(tag, phase, ph);
  endtask

  initial begin
    int nclr;
    @(negedge clk);
    // Reset
    reset = 0; cycle(); cycle();
    chk("rst_phase", phase, IDLE);
    chk("rst_ready", move_ready, 0);
    reset = 1; cycle();
    // New game: board_clear, spawn_en, then FALL
    start = 1; cycle(); start = 0;
    chk("start_bclr", board_clear, 1);
    cycle(); chk("spawn_pulse", spawn_en, 1);
    cycle(); chk("fall_reached", phase, FALL);
    // Gravity every 4 ticks, then lock on a blocked drop
    tick = 1;
    repeat (13) cycle();
    down_blocked = 1;
    run_until(LOCK, 10, "lock_reached");
    // Three full rows, one clear per two cycles
    any_full_row = 1; nclr = 0;
    for (int i = 0; i < 12 && m_phase != SPAWN; i++) begin
      cycle();
      if (clear_en) nclr++;
      if (m_lines >= 3) any_full_row = 0;
    end
    chk("clear_count", nclr, 3);
    chk("clear_lines", lines_cleared, 3);
    down_blocked = 0;
    run_until(FALL, 6, "refall");
    // Move arriving with the gravity event loses and is taken next cycle
    for (int i = 0; i < 8 && !m_due(); i++) cycle();
    move_valid = 1; move = CMD_LEFT;
    cycle(); chk("coll_drop", drop_en, 1); chk("coll_nomove", move_en, 0);
    cycle(); chk("coll_move", move_en, 1); chk("coll_cmd", move_cmd, CMD_LEFT);
    move_valid = 0;
    // Long clear run to saturate the level
    down_blocked = 1;
    run_until(LOCK, 10, "lock2");
    any_full_row = 1;
    repeat (70) cycle();
    chk("level_cap", level, 15);
    any_full_row = 0; down_blocked = 0;
    // Blocked spawn ends the game; moves and ticks are ignored
    run_until(SETTLE, 6, "settle");
    spawn_blocked = 1; cycle(); spawn_blocked = 0;
    chk("over", game_over, 1);
    move_valid = 1; move = CMD_RIGHT;
    repeat (6) cycle();
    move_valid = 0;
    reset = 0; cycle(); reset = 1;
    chk("over_rst", game_over, 0);
    // Reset in CLEAR_WAIT leaves no residue
    start = 1; cycle(); start = 0;
    down_blocked = 1; any_full_row = 1;
    run_until(CLEAR_WAIT, 20, "cw_reached");
    reset = 0; cycle(); reset = 1;
    chk("cw_rst_phase", phase, IDLE);
    cycle();
    // Random play
    for (int i = 0; i < 4000; i++) begin
      reset         = ($urandom_range(0, 299) != 0);
      start         = ($urandom_range(0, 149) == 0);
      tick          = $urandom_range(0, 1);
      move_valid    = $urandom_range(0, 1);
      move          = command_t'($urandom_range(0, 5));
      left_blocked  = ($urandom_range(0, 3) == 0);
      right_blocked = ($urandom_range(0, 3) == 0);
      rot_blocked   = ($urandom_range(0, 3) == 0);
      down_blocked  = ($urandom_range(0, 2) == 0);
      spawn_blocked = ($urandom_range(0, 29) == 0);
      any_full_row  = ($urandom_range(0, 2) != 0);
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
